// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, start-glitch
// rejection and stop-bit framing check. Emits one-cycle axiov / frame_err pulses.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiid,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          s1, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= axiid;
      rxs <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      axiov     <= 1'b0;
      axiod     <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      axiov     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            sh      <= {rxs, sh[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rxs) begin
              axiod <= sh;
              axiov <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // Held-low line: wait for a return to idle before re-arming.
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: scoreboard of expected bytes / framing
// errors, popped as the receiver pulses axiov or frame_err.
module tb_uart_rx_framer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       axiid = 1'b1;
  logic       axiov, frame_err, busy;
  logic [7:0] axiod;

  typedef struct packed {logic err; logic [7:0] d;} exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .frame_err(frame_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Bit widths alternate 16+skew / 16-skew: each bit is off by a clock while
  // the cumulative error stays within one clock of the nominal edge.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int skew);
    logic [9:0] bits;
    bits = {stopv, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      axiid = bits[i];
      repeat (CPB + (((i % 2) == 0) ? skew : -skew)) @(negedge clk);
    end
  endtask

  task automatic collect(input string tag, input int n, input int budget);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (axiov || frame_err) begin
        got++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $error("FAIL %s: unexpected pulse axiov=%0b frame_err=%0b axiod=%0h", tag, axiov, frame_err, axiod);
        end else begin
          e = sb.pop_front();
          assert ({axiov, frame_err, axiod} === {~e.err, e.err, e.d}) else begin
            fails++;
            $error("FAIL %s: got v=%0b err=%0b d=%0h, want v=%0b err=%0b d=%0h",
                   tag, axiov, frame_err, axiod, ~e.err, e.err, e.d);
          end
        end
      end
    end
    tests++;
    assert (got == n) else begin
      fails++;
      $error("FAIL %s_timeout: got %0d events, want %0d", tag, got, n);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (axiov || frame_err) pulses++;
    end
    check(tag, 32'(pulses), 32'h0);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_axiov", 32'(axiov), 32'h0);
    check("rst_axiod", 32'(axiod), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single ideal frame
    sb.push_back('{1'b0, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1, 0);
      collect("a5", 1, 20*CPB);
    join
    quiet("a5_quiet", 4*CPB);
    check("a5_busy", 32'(busy), 32'h0);

    // Back-to-back frames, no idle gap
    sb.push_back('{1'b0, 8'h00});
    sb.push_back('{1'b0, 8'hFF});
    fork
      begin send_frame(8'h00, 1'b1, 0); send_frame(8'hFF, 1'b1, 0); end
      collect("b2b", 2, 30*CPB);
    join
    quiet("b2b_quiet", 4*CPB);

    // 4-clock low glitch on idle line
    axiid = 1'b0;
    repeat (4) @(negedge clk);
    axiid = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    quiet("glitch_quiet", 4*CPB);
    check("glitch_axiod", 32'(axiod), 32'hFF);
    check("glitch_busy_lo", 32'(busy), 32'h0);

    // Stop bit low then held-low break for 40 bit times
    sb.push_back('{1'b1, 8'hFF});
    fork
      begin send_frame(8'h3C, 1'b0, 0); repeat (40*CPB) @(negedge clk); end
      begin collect("brk", 1, 20*CPB); quiet("brk_quiet", 20*CPB); end
    join
    check("brk_busy_hi", 32'(busy), 32'h1);
    axiid = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_busy_lo", 32'(busy), 32'h0);
    check("brk_axiod", 32'(axiod), 32'hFF);

    // Async reset during data bit 4 of 8'h81; stray frame afterwards is ignored
    axiid = 1'b0; repeat (CPB) @(negedge clk);
    axiid = 1'b1; repeat (CPB) @(negedge clk);
    axiid = 1'b0; repeat (3*CPB) @(negedge clk);
    repeat (CPB/2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_axiov", 32'(axiov), 32'h0);
    check("mid_rst_axiod", 32'(axiod), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_ferr",  32'(frame_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB/2 - 1) @(negedge clk);
    repeat (2*CPB) @(negedge clk);
    axiid = 1'b1; repeat (2*CPB) @(negedge clk);
    w = 0;
    while (busy && w < 40*CPB) begin
      @(negedge clk);
      w++;
    end
    check("stray_done", 32'(busy), 32'h0);
    repeat (2*CPB) @(negedge clk);
    sb.push_back('{1'b0, 8'h42});
    fork
      send_frame(8'h42, 1'b1, 0);
      collect("post_rst", 1, 20*CPB);
    join
    check("post_rst_axiod", 32'(axiod), 32'h42);

    // Baud skew, both directions
    sb.push_back('{1'b0, 8'h5A});
    fork
      send_frame(8'h5A, 1'b1, 1);
      collect("skew_p", 1, 20*CPB);
    join
    quiet("skew_p_quiet", 2*CPB);
    sb.push_back('{1'b0, 8'h5A});
    fork
      send_frame(8'h5A, 1'b1, -1);
      collect("skew_n", 1, 20*CPB);
    join
    quiet("skew_n_quiet", 2*CPB);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- 8N1 UART receiver that turns the asynchronous PC serial line into one-byte-wide valid pulses.
- Sits directly upstream of the PC-to-FPGA command/display logic: its axiov/axiod pair feeds that stage's byte capture.
- Adds an input synchronizer, mid-bit sampling, start-glitch rejection and stop-bit framing checks.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 4.
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit midpoint check.

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  reset, asynchronous, active-low
axiid  input  1  raw serial line from PC; idle high
axiov  output  1  one-cycle pulse: axiod holds a newly received good byte
axiod  output  8  last good received byte; holds between pulses
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): both synchronizer flops = 1; state = IDLE; counters = 0; axiov = 0, axiod = 8'h00, frame_err = 0, busy = 0.
- Synchronizer: 2-flop chain on axiid produces rxs. Every rx decision below uses rxs, which lags axiid by 2 clk.
- Counter cnt: counts cycles within the current bit; cleared on every state change. bit_idx (3 bits) counts data bits.
- IDLE: if rxs == 0 -> START, cnt = 0.
- START: when cnt == HALF_BIT-1:
  - rxs == 0 -> DATA, cnt = 0, bit_idx = 0.
  - rxs == 1 -> IDLE (glitch rejected; no pulse).
- DATA: when cnt == CLKS_PER_BIT-1:
  - Shift rxs into the MSB of shift register sh (shift right, LSB first on the wire).
  - cnt = 0; bit_idx += 1.
  - After the 8th sample (bit_idx == 7) -> STOP.
- STOP: when cnt == CLKS_PER_BIT-1, sample rxs:
  - rxs == 1: axiod <= sh; axiov = 1 for exactly one cycle; -> IDLE.
  - rxs == 0: frame_err = 1 for one cycle; axiod unchanged; -> BREAK.
- BREAK: wait for rxs == 1, then -> IDLE. A held-low line (break condition) never produces repeated bytes.
- Latency: axiov rises at approximately the stop-bit midpoint. This is 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the axiid falling edge.
- axiov and frame_err are never high in the same cycle. Each is low in every cycle other than its own event cycle.
- Back-to-back frames: a start edge arriving immediately after the stop-bit sample is accepted. No idle gap beyond the stop bit is required.
- Reset asserted mid-frame: all state is lost immediately and no pulse is produced. After release the receiver waits in IDLE. A partial frame still in progress on the line may be misread as a start edge, and that stray frame must end in either a valid byte or frame_err, never a hang.
- No parity; no FIFO. The consumer must take axiod on the axiov cycle or from the held value.

Test Plan:
(bench uses CLKS_PER_BIT=16)
- Send 8'hA5, 8N1, ideal timing -> exactly one axiov pulse, axiod=8'hA5, frame_err never high, busy low afterwards.
- Send 8'h00 then 8'hFF back-to-back, no gap -> two axiov pulses, in order 8'h00, 8'hFF; no frame_err.
- Low glitch of 4 clk on idle line -> START entered then IDLE; no axiov, no frame_err; axiod keeps previous value (8'hFF).
- Send 8'h3C with stop bit forced low, then hold line low 40 bit times, then release -> exactly one frame_err pulse, no axiov, axiod unchanged, busy high until the line returns high.
- Pulse rst_n low during data bit 4 of 8'h81 -> axiov=0, axiod=8'h00, busy=0 immediately (async). Next clean frame 8'h42 -> axiod=8'h42.
- Baud skew: send 8'h5A at 16±1 clk per bit -> axiod=8'h5A received correctly in both cases.
